// File: rtl/zdos_trap_if.sv
// Bus bundle between the Z80 bus interface, the DOS flag register and zdos_trap.
// The master side drives the Z80 bus and the flag status. The slave side is the trap monitor.
interface zdos_trap_if;
  logic        m1_n;
  logic        mreq_n;
  logic [15:0] za;
  logic        rom48;
  logic        dos;
  logic        trap_en;
  logic        dos_turn_on;
  logic        dos_turn_off;
  logic        m1_active;

  modport master (
    output m1_n, mreq_n, za, rom48, dos, trap_en,
    input  dos_turn_on, dos_turn_off, m1_active
  );

  modport slave (
    input  m1_n, mreq_n, za, rom48, dos, trap_en,
    output dos_turn_on, dos_turn_off, m1_active
  );
endinterface

// File: rtl/zdos_trap.sv
// Z80 opcode-fetch monitor that sequences the DOS paging flag.
// A fetch must be seen on QUAL_CYC consecutive synchronized samples before it is accepted.
// On acceptance the fetch address is latched and both trap conditions are evaluated.
// The turn-on pulse follows the latch. The turn-off pulse fires once M1 returns high.
module zdos_trap #(
  parameter logic [7:0]  ON_PAGE  = 8'h3D,
  parameter int unsigned QUAL_CYC = 2
) (
  input logic        fclk,
  input logic        rst_n,
  zdos_trap_if.slave bus
);

  localparam logic [2:0] QualCyc = 3'(QUAL_CYC);

  typedef enum logic [1:0] {StIdle, StQual, StActive, StEnd} state_e;

  state_e      state_q;
  logic [1:0]  m1_sync_q;
  logic [1:0]  mreq_sync_q;
  logic [2:0]  qcnt_q;
  logic [15:0] alat_q;
  logic        off_pend_q;
  logic        turn_on_q;
  logic        turn_off_q;
  logic        active_q;

  logic        m1s;
  logic        mreqs;
  logic        fetch;
  logic        on_cond;
  logic        off_cond;
  logic [2:0]  qcnt_inc;
  logic        qual_done;

  // Two-flop synchronizers for the asynchronous Z80 strobes; idle level is high.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      m1_sync_q   <= 2'b11;
      mreq_sync_q <= 2'b11;
    end else begin
      m1_sync_q   <= {m1_sync_q[0], bus.m1_n};
      mreq_sync_q <= {mreq_sync_q[0], bus.mreq_n};
    end
  end

  // Fetch detection, qualify-count compare and the two trap conditions.
  always_comb begin
    m1s       = m1_sync_q[1];
    mreqs     = mreq_sync_q[1];
    fetch     = ~m1s & ~mreqs;
    qcnt_inc  = qcnt_q + 3'd1;
    // From IDLE qcnt is 0, so QUAL_CYC = 1 latches on the first fetch sample.
    qual_done = (qcnt_inc == QualCyc);
    on_cond   = bus.trap_en & ~bus.dos & bus.rom48 & (bus.za[15:8] == ON_PAGE);
    off_cond  = bus.trap_en & bus.dos & (bus.za[15:14] != 2'b00);
  end

  // Fetch sequencer. The pulses default low, so each one lasts exactly one fclk.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      qcnt_q     <= 3'd0;
      alat_q     <= 16'h0000;
      off_pend_q <= 1'b0;
      turn_on_q  <= 1'b0;
      turn_off_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      turn_on_q  <= 1'b0;
      turn_off_q <= 1'b0;
      unique case (state_q)
        StIdle, StQual: begin
          if (!fetch) begin
            // A fetch that drops before qualifying is ignored entirely.
            state_q <= StIdle;
            qcnt_q  <= 3'd0;
          end else if (qual_done) begin
            qcnt_q     <= qcnt_inc;
            alat_q     <= bus.za;
            off_pend_q <= off_cond;
            turn_on_q  <= on_cond;
            active_q   <= 1'b1;
            state_q    <= StActive;
          end else begin
            qcnt_q  <= qcnt_inc;
            state_q <= StQual;
          end
        end
        StActive: begin
          if (m1s) begin
            turn_off_q <= off_pend_q;
            off_pend_q <= 1'b0;
            active_q   <= 1'b0;
            state_q    <= StEnd;
          end
        end
        StEnd: begin
          qcnt_q  <= 3'd0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.dos_turn_on  = turn_on_q;
  assign bus.dos_turn_off = turn_off_q;
  assign bus.m1_active    = active_q;

  // Disjoint address ranges and opposite dos conditions keep the pulses exclusive.
  assert property (@(posedge fclk) disable iff (!rst_n) !(turn_on_q && turn_off_q));

  // The latched address is the one presented on the latching edge.
  assert property (@(posedge fclk) disable iff (!rst_n) $rose(active_q) |-> alat_q == $past(bus.za));

endmodule

// File: doc/zdos_trap.md
# zdos_trap

Z80 opcode-fetch monitor that sequences the DOS paging flag. It watches synchronized Z80 M1/MREQ activity and the fetch address, then issues single-fclk `dos_turn_on` / `dos_turn_off` pulses to the DOS flag register. Turn-on fires on an opcode fetch from the DOS entry page while the 48K BASIC ROM is mapped. Turn-off fires at the end of an opcode fetch from RAM (address ≥ 4000h). It sits between the Z80 bus interface and the DOS flag register; `cpm_n` override stays in the flag register.

## Interface
Parameters:
- ON_PAGE, 8'h3D — high address byte (za[15:8]) of the DOS entry trap page
- QUAL_CYC, 2 — consecutive fclk samples of M1&MREQ low needed to accept a fetch (1..7)

Ports (reset rst_n, asynchronous, active-low; clock fclk):
- fclk  in  1  system clock
- rst_n  in  1  async active-low reset
- m1_n  in  1  Z80 M1, asynchronous to fclk
- mreq_n  in  1  Z80 MREQ, asynchronous to fclk
- za  in  16  Z80 address, stable while M1&MREQ low
- rom48  in  1  1 = 48K BASIC ROM currently mapped at 0000h
- dos  in  1  current DOS flag (feedback from flag register)
- trap_en  in  1  1 = traps enabled; 0 = no pulses generated
- dos_turn_on  out  1  one-fclk pulse: set DOS
- dos_turn_off  out  1  one-fclk pulse: clear DOS
- m1_active  out  1  high while a qualified fetch is in progress (state ACTIVE)

## Operation
- m1_n and mreq_n pass through 2-flop synchronizers (reset value 1) → m1s, mreqs. `fetch` = !m1s & !mreqs.
- 3-bit qualify counter `qcnt`, and a 16-bit address latch `alat`.
- Two pending flags:
  - `off_pend` is set at latch when `trap_en & dos & (za[15:14] != 2'b00)`.
  - The turn-on condition at latch is `trap_en & !dos & rom48 & (za[15:8] == ON_PAGE)`.
- State machine:
  - IDLE: qcnt = 0. If fetch → QUAL with qcnt = 1.
  - QUAL: if !fetch → IDLE; no pulse, no latch. Else qcnt++. When qcnt reaches QUAL_CYC: latch za into alat, evaluate both conditions, go to ACTIVE.
  - ACTIVE: if m1s == 1 → END.
  - END: dos_turn_off = off_pend; clear off_pend; → IDLE.
- QUAL_CYC = 1: the first fetch sample latches directly from IDLE; QUAL is skipped.
- dos_turn_on is registered; it pulses the cycle after latch when the turn-on condition held.
- Turn-on and turn-off are mutually exclusive by construction: they have disjoint address ranges and opposite dos conditions. Both outputs are never high in the same cycle.
- Refresh cycles (MREQ low, M1 high) never qualify.
- An interrupt acknowledge cycle (M1 low, MREQ high) never qualifies.
- Changes to trap_en, dos or rom48 after latch do not affect the current fetch.
- A new fetch is accepted only from IDLE. Back-to-back fetches need m1s to return high between them.
- Reset, at any time including mid-fetch: state IDLE, qcnt 0, off_pend 0, synchronizers 1, alat 0. All outputs are 0 at reset.

## Timing
- Let cycle n be the first fclk on which `fetch` is 1.
  - Latch occurs at n + QUAL_CYC − 1.
  - dos_turn_on is high exactly at cycle n + QUAL_CYC.
- Raw bus to pulse: turn-on appears 2 + QUAL_CYC fclk after M1&MREQ fall.
- m1_active rises with entry to ACTIVE (n + QUAL_CYC) and falls on entry to END.
- Let k be the first ACTIVE cycle with m1s == 1.
  - END occurs at k + 1, and dos_turn_off is high only at k + 1.
  - IDLE is reached at k + 2.
- Pulse width is always exactly 1 fclk.

## Test plan
- Trap on: rom48 = 1, dos = 0, trap_en = 1, fetch at 3D2Fh with M1/MREQ low for 10 fclk → one dos_turn_on pulse at 4 fclk after the raw fall (QUAL_CYC = 2); no dos_turn_off.
- Trap off: dos = 1, fetch at 8000h → dos_turn_on stays 0. One dos_turn_off pulse 1 fclk after synchronized m1_n rises. A fetch at 3D00h with dos = 1 gives no pulses.
- Qualification: MREQ low for only 1 fclk during M1 at 3D00h → no pulse. Refresh cycle (M1 high) at 3D00h → no pulse. rom48 = 0 or trap_en = 0 at 3D00h → no pulse.
- Boundaries:
  - Fetches at 3CFFh and 3E00h → no turn_on.
  - Fetch at 3FFFh with dos = 1 → no turn_off.
  - Fetch at 4000h with dos = 1 → turn_off.
- Mid-operation: assert rst_n low during ACTIVE of an 8000h fetch with dos = 1 → no dos_turn_off afterward; m1_active = 0 immediately. The next fetch behaves normally.
- Back-to-back: two fetches 3D00h then C000h with dos following the pulses → exactly one turn_on and then one turn_off, never in the same cycle.
